// File: rtl/ycbcr2rgb.sv
// Full-range YCbCr -> RGB (T.871/JFIF), five register stages, rounded and saturated.
// Data stages load every cycle; only the valid/sof shift register qualifies them.
module ycbcr2rgb #(
  parameter int FRAC = 14
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iValid,
  input  logic       iSof,
  input  logic [7:0] iY,
  input  logic [7:0] iCb,
  input  logic [7:0] iCr,
  output logic       oValid,
  output logic       oSof,
  output logic [7:0] oR,
  output logic [7:0] oG,
  output logic [7:0] oB
);
  localparam int STAGES = 5;
  localparam int P      = FRAC + 11;

  // round(k * 2^FRAC) in 64-bit integer arithmetic
  localparam longint ONE   = longint'(1) << FRAC;
  localparam longint KR_L  = (1402 * ONE + 500) / 1000;
  localparam longint KGB_L = (344136 * ONE + 500000) / 1000000;
  localparam longint KGR_L = (714136 * ONE + 500000) / 1000000;
  localparam longint KB_L  = (1772 * ONE + 500) / 1000;

  localparam logic signed [P-1:0] KR  = P'(KR_L);
  localparam logic signed [P-1:0] KGB = P'(KGB_L);
  localparam logic signed [P-1:0] KGR = P'(KGR_L);
  localparam logic signed [P-1:0] KB  = P'(KB_L);
  localparam logic signed [P-1:0] RND = {{(P-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  logic [STAGES-1:0] vld_pipe_q, sof_pipe_q;

  logic        [8:0] y1_q;
  logic signed [8:0] cb1_q, cr1_q, cb1_d, cr1_d;

  logic        [8:0]   y2_q;
  logic signed [P-1:0] prr_q, pgb_q, pgr_q, pbb_q;
  logic signed [P-1:0] prr_d, pgb_d, pgr_d, pbb_d;
  logic signed [P-1:0] cb_x, cr_x, yw;

  logic [2:0][P-1:0]  sum_q, sum_d;
  logic [2:0][10:0]   scl_q;
  logic [2:0][7:0]    rgb_q;

  assign cb1_d = {1'b0, iCb} - 9'd128;
  assign cr1_d = {1'b0, iCr} - 9'd128;

  assign cb_x  = {{(P-9){cb1_q[8]}}, cb1_q};
  assign cr_x  = {{(P-9){cr1_q[8]}}, cr1_q};
  assign prr_d = cr_x * KR;
  assign pgb_d = cb_x * KGB;
  assign pgr_d = cr_x * KGR;
  assign pbb_d = cb_x * KB;

  assign yw       = {{(P-9-FRAC){1'b0}}, y2_q, {FRAC{1'b0}}};
  assign sum_d[0] = yw + RND + prr_q;
  assign sum_d[1] = yw + RND - pgb_q - pgr_q;
  assign sum_d[2] = yw + RND + pbb_q;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      vld_pipe_q <= '0;
      sof_pipe_q <= '0;
      y1_q       <= '0;
      cb1_q      <= '0;
      cr1_q      <= '0;
      y2_q       <= '0;
      prr_q      <= '0;
      pgb_q      <= '0;
      pgr_q      <= '0;
      pbb_q      <= '0;
      sum_q      <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-2:0], iValid};
      sof_pipe_q <= {sof_pipe_q[STAGES-2:0], iSof & iValid};
      y1_q       <= {1'b0, iY};
      cb1_q      <= cb1_d;
      cr1_q      <= cr1_d;
      y2_q       <= y1_q;
      prr_q      <= prr_d;
      pgb_q      <= pgb_d;
      pgr_q      <= pgr_d;
      pbb_q      <= pbb_d;
      sum_q      <= sum_d;
    end
  end

  // Per-channel floor-shift and saturate
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [10:0] scl_d;
    logic [7:0]  rgb_d;

    assign scl_d = sum_q[c][FRAC+10:FRAC];

    always_comb begin
      rgb_d = scl_d[7:0];
      if (scl_d[10])            rgb_d = 8'd0;
      else if (scl_d[9:8] != 0) rgb_d = 8'd255;
    end

    always_ff @(posedge iClk) begin
      if (iRst) begin
        scl_q[c] <= '0;
        rgb_q[c] <= '0;
      end else begin
        scl_q[c] <= scl_d;
        rgb_q[c] <= rgb_d;
      end
    end
  end

  // Stage-5 clamp works from the registered stage-4 value
  logic [2:0][7:0] sat_q;
  for (genvar c = 0; c < 3; c++) begin : g_out
    logic [7:0] sat_d;
    always_comb begin
      sat_d = scl_q[c][7:0];
      if (scl_q[c][10])            sat_d = 8'd0;
      else if (scl_q[c][9:8] != 0) sat_d = 8'd255;
    end
    always_ff @(posedge iClk) begin
      if (iRst) sat_q[c] <= '0;
      else      sat_q[c] <= sat_d;
    end
  end

  assign oValid = vld_pipe_q[STAGES-1];
  assign oSof   = sof_pipe_q[STAGES-1];
  assign oR     = sat_q[0];
  assign oG     = sat_q[1];
  assign oB     = sat_q[2];

  logic unused_ok;
  assign unused_ok = ^rgb_q;
endmodule

// File: tb/tb_ycbcr2rgb.sv
// Directed + random bench for ycbcr2rgb; expected pixels are queued with the cycle they are due.
module tb_ycbcr2rgb;
  logic       iClk = 1'b0;
  logic       iRst, iValid, iSof;
  logic [7:0] iY, iCb, iCr;
  logic       oValid, oSof;
  logic [7:0] oR, oG, oB;

  ycbcr2rgb dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .iSof(iSof),
    .iY(iY), .iCb(iCb), .iCr(iCr),
    .oValid(oValid), .oSof(oSof), .oR(oR), .oG(oG), .oB(oB)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int         due;
    logic       sof;
    logic [7:0] r, g, b;
  } exp_t;

  exp_t q[$];
  int   cyc = 0, errors = 0, checks = 0, last_rst = -100;
  logic       fix_en = 1'b0;
  logic [7:0] fix_r, fix_g, fix_b;

  function automatic int sat8(int v);
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // JFIF inverse transform in fixed point with FRAC=14, round half up
  function automatic logic [23:0] model(int y, int cb, int cr);
    int r, g, b, c1, c2;
    c1 = cb - 128;
    c2 = cr - 128;
    r = ((y * 16384) + 8192 + c2 * 22970) >>> 14;
    g = ((y * 16384) + 8192 - c1 * 5638 - c2 * 11700) >>> 14;
    b = ((y * 16384) + 8192 + c1 * 29032) >>> 14;
    return {8'(sat8(r)), 8'(sat8(g)), 8'(sat8(b))};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic tick();
    exp_t e;
    logic [23:0] m;
    @(posedge iClk);
    cyc++;
    if (iRst) begin
      q.delete();
      last_rst = cyc;
    end else if (iValid) begin
      m     = model(int'(iY), int'(iCb), int'(iCr));
      e.due = cyc + 4;
      e.sof = iSof;
      e.r   = fix_en ? fix_r : m[23:16];
      e.g   = fix_en ? fix_g : m[15:8];
      e.b   = fix_en ? fix_b : m[7:0];
      q.push_back(e);
    end
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("valid", 32'(oValid), 32'd1);
      chk("sof",   32'(oSof),   32'(q[0].sof));
      chk("rgb",   {8'd0, oR, oG, oB}, {8'd0, q[0].r, q[0].g, q[0].b});
      void'(q.pop_front());
    end else begin
      chk("idle_valid", 32'(oValid), 32'd0);
      chk("idle_sof",   32'(oSof),   32'd0);
      if (cyc - last_rst < 4)
        chk("rst_zero", {8'd0, oR, oG, oB}, 32'd0);
    end
  endtask

  task automatic px_fixed(input logic [7:0] y, cb, cr, er, eg, eb);
    iValid = 1'b1; iSof = 1'b0; iY = y; iCb = cb; iCr = cr;
    fix_en = 1'b1; fix_r = er; fix_g = eg; fix_b = eb;
    tick();
    fix_en = 1'b0;
  endtask

  task automatic px_rand(input logic v, input logic s);
    iValid = v; iSof = s;
    iY = 8'($urandom); iCb = 8'($urandom); iCr = 8'($urandom);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px_rand(1'b0, 1'($urandom));
  endtask

  initial begin
    logic [6:0] gaps;
    iRst = 1'b1; iValid = 1'b0; iSof = 1'b0; iY = '0; iCb = '0; iCr = '0;
    tick(); tick();
    iRst = 1'b0;
    idle(2);

    // directed values, back-to-back
    px_fixed(8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128);
    px_fixed(8'd255, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255);
    px_fixed(8'd0,   8'd128, 8'd128, 8'd0,   8'd0,   8'd0);
    px_fixed(8'd76,  8'd85,  8'd255, 8'd254, 8'd0,   8'd0);
    px_fixed(8'd0,   8'd0,   8'd0,   8'd0,   8'd135, 8'd0);
    px_fixed(8'd255, 8'd0,   8'd255, 8'd255, 8'd208, 8'd28);
    idle(6);

    // 64-pixel stream, sof on first
    for (int i = 0; i < 64; i++) px_rand(1'b1, i == 0);
    idle(6);

    // gap pattern 1,0,0,1,1,0,1
    gaps = 7'b1011001;
    for (int i = 0; i < 7; i++) px_rand(gaps[i], 1'b0);
    idle(6);

    // reset with three pixels in flight; iRst wins over iValid
    for (int i = 0; i < 3; i++) px_rand(1'b1, i == 0);
    iRst = 1'b1;
    px_rand(1'b1, 1'b1);
    px_rand(1'b1, 1'b0);
    iRst = 1'b0;
    idle(2);
    px_rand(1'b1, 1'b1);
    idle(6);

    for (int i = 0; i < 200; i++) px_rand(1'($urandom), 1'($urandom));
    idle(6);

    chk("drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ycbcr2rgb.md
# ycbcr2rgb

Pipelined full-range YCbCr → RGB converter (ITU-T T.871 / JFIF), the inverse of the RGB→YCbCr stage in the image-processing path. It accepts one 8-bit YCbCr pixel per clock with a valid and a start-of-frame flag. It returns the 8-bit RGB pixel with fixed five-cycle latency, rounded and saturated. It sits after the YCbCr-domain filters and feeds the RGB video/PPM output path.

## Interface
- FRAC, 14, fractional bits of the fixed-point coefficients (range 10..16).
- iClk  in  1  single clock; all registers update on the rising edge.
- iRst  in  1  reset; one clock, synchronous, active-high.
- iValid  in  1  iY/iCb/iCr hold a pixel this cycle.
- iSof  in  1  first pixel of a frame; meaningful only with iValid.
- iY  in  8  luma, unsigned 0..255.
- iCb  in  8  blue-difference chroma, unsigned, offset 128.
- iCr  in  8  red-difference chroma, unsigned, offset 128.
- oValid  out  1  oR/oG/oB hold a converted pixel.
- oSof  out  1  iSof delayed with its pixel.
- oR, oG, oB  out  8 each  RGB, unsigned 0..255.

## Operation
- Coefficients are round(k·2^FRAC). For FRAC=14: KR=22970 (1.402), KGB=5638 (0.344136), KGR=11700 (0.714136), KB=29032 (1.772).
- Stage 1 (input register):
  - y = {0,iY}.
  - cb = iCb−128 and cr = iCr−128, both signed 9-bit, range −128..127.
  - Capture iValid and iSof.
- Stage 2 (multiply): register the signed products cr·KR, cb·KGB, cr·KGR and cb·KB. Width is 9+FRAC+2 bits signed, with no overflow.
- Stage 3 (sum): with RND = 2^(FRAC−1):
  - sR = (y<<FRAC) + RND + cr·KR
  - sG = (y<<FRAC) + RND − cb·KGB − cr·KGR
  - sB = (y<<FRAC) + RND + cb·KB
  - Accumulators are wide enough for no overflow (FRAC+11 bits signed).
- Stage 4 (scale): arithmetic shift right by FRAC, which floors. Together with RND this gives round-half-up. Result is signed 11-bit.
- Stage 5 (clamp): value <0 → 0; value >255 → 255; otherwise the low 8 bits. Register into oR/oG/oB.
- Valid/Sof path: a 5-deep shift register moves alongside the data, giving oValid and oSof.
  - Data stages load every cycle regardless of valid.
  - Outputs while oValid=0 are don't-care to consumers, but must be deterministic (see reset).
- No backpressure. Throughput is one pixel per clock, and there is no stall input.
- iSof without iValid is ignored; the stage-1 sof bit is iSof & iValid.

## Timing
- Latency: a pixel sampled with iValid=1 at rising edge N appears on oR/oG/oB with oValid=1 immediately after edge N+4. That is five register stages, and edge N loads stage 1.
- Back-to-back valid inputs on consecutive edges produce back-to-back valid outputs.
- Gaps in iValid reproduce as identical gaps in oValid, with the same spacing.
- Reset:
  - An edge with iRst=1 clears all valid/sof pipeline bits and every data register to 0.
  - After that edge: oValid=0, oSof=0, oR=oG=oB=0.
  - iRst takes priority over iValid on the same edge; that pixel is discarded.
- Reset mid-stream: all in-flight pixels are lost, and no valid output appears during reset.
  - The first valid output after reset is the first pixel sampled on an edge with iRst=0 and iValid=1, at edge+4.
  - While iRst stays high across several edges, outputs remain 0.
- Saturation is per-channel and independent. No internal signal wraps for any of the 2^24 inputs.

## Test plan
- Grey and extremes: (Y,Cb,Cr) = (128,128,128) → (128,128,128); (255,128,128) → (255,255,255); (0,128,128) → (0,0,0).
- Rounding and low clamp: (76,85,255) → R=254, G=0, B=0. (0,0,0) → (0,135,0), where R and B clamp from negative.
- High clamp: (255,0,255) → (255,208,28), with R saturating from 433.
- Latency and streaming:
  - 64 consecutive valid pixels with iSof on the first → oValid rises exactly 4 cycles after the first sampling edge and stays high for 64 cycles.
  - oSof is high only on the first output.
  - Outputs match the golden model bit-exactly.
- Gaps: iValid pattern 1,0,0,1,1,0,1 → the identical oValid pattern, delayed by 4 cycles, with correct data on each valid cycle.
- Reset mid-stream: assert iRst for 2 edges while 3 pixels are in flight.
  - Expected: oValid=0 and outputs 0 from the reset edge onward.
  - None of the 3 in-flight pixels emerge.
  - The next valid pixel emerges 4 cycles after its sampling edge.
- Full-image regression: a 64×64 PPM is round-tripped through the RGB→YCbCr stage and then this block. Expected per-channel |error| ≤ 3 against the source image, and exact match to the fixed-point C model.
